// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: op encodings, MEM/WB stage states
// and the default datapath dimensions.
package cpu_pkg;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int RW  = 2;
    localparam int TMO = 15;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } mwb_state_t;

endpackage

// File: rtl/mem_wb_stage_wb_reg.sv
// Register-file write port flop stage: selects ALU or load writeback and
// registers the single write strobe, address and data.
module wb_reg
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int RW = cpu_pkg::RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_en,
    input  logic          sel_load,
    input  logic [RW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic [RW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          rf_wr_en,
    output logic [RW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_dat_in
);

    logic [RW-1:0] addr_s;
    logic [DW-1:0] data_s;

    // 2:1 writeback source select
    always_comb begin
        addr_s = alu_addr;
        data_s = alu_data;
        if (sel_load) begin
            addr_s = ld_addr;
            data_s = ld_data;
        end else begin
            addr_s = alu_addr;
            data_s = alu_data;
        end
    end

    // Output flops; address/data hold their last written value between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= {RW{1'b0}};
            rf_dat_in  <= {DW{1'b0}};
        end else begin
            rf_wr_en <= wb_en;
            if (wb_en) begin
                rf_wr_addr <= addr_s;
                rf_dat_in  <= data_s;
            end
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access + writeback stage: drives the data-memory port, owns the
// register-file write port and tracks pending loads for hazard stalls.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DW  = cpu_pkg::DW,
    parameter int AW  = cpu_pkg::AW,
    parameter int RW  = cpu_pkg::RW,
    parameter int TMO = cpu_pkg::TMO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [1:0]       ex_op,
    input  logic [RW-1:0]    ex_dst,
    input  logic [DW-1:0]    ex_result,
    input  logic [DW-1:0]    ex_sdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic             mem_ready,
    input  logic             mem_rvalid,
    input  logic [DW-1:0]    mem_rdata,
    output logic             rf_wr_en,
    output logic [RW-1:0]    rf_wr_addr,
    output logic [DW-1:0]    rf_dat_in,
    output logic [2**RW-1:0] busy_mask,
    output logic             err
);

    localparam int NR = 2**RW;
    localparam int CW = $clog2(TMO+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TMO);

    mwb_state_t    state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          req_nxt_s, we_nxt_s, is_load_r, is_load_nxt_s, err_nxt_s;
    logic [AW-1:0] addr_nxt_s;
    logic [DW-1:0] wdata_nxt_s;
    logic [RW-1:0] dst_r, dst_nxt_s;
    logic [NR-1:0] busy_nxt_s;
    logic          wb_en_s, wb_sel_load_s, transfer_s;
    op_t           op_s;

    assign ex_ready   = (state_r == ST_IDLE);
    assign transfer_s = ex_valid & ex_ready;
    assign op_s       = op_t'(ex_op);

    // Next-state, latch updates, timeout and scoreboard decisions
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        req_nxt_s     = mem_req;
        we_nxt_s      = mem_we;
        addr_nxt_s    = mem_addr;
        wdata_nxt_s   = mem_wdata;
        dst_nxt_s     = dst_r;
        is_load_nxt_s = is_load_r;
        busy_nxt_s    = busy_mask;
        err_nxt_s     = err;
        wb_en_s       = 1'b0;
        wb_sel_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (transfer_s) begin
                    case (op_s)
                        OP_ALU: begin
                            wb_en_s = 1'b1;
                        end
                        OP_LOAD: begin
                            state_nxt_s   = ST_REQ;
                            cnt_nxt_s     = {CW{1'b0}};
                            req_nxt_s     = 1'b1;
                            we_nxt_s      = 1'b0;
                            addr_nxt_s    = ex_result[AW-1:0];
                            dst_nxt_s     = ex_dst;
                            is_load_nxt_s = 1'b1;
                            busy_nxt_s    = {{(NR-1){1'b0}}, 1'b1} << ex_dst;
                        end
                        OP_STORE: begin
                            state_nxt_s   = ST_REQ;
                            cnt_nxt_s     = {CW{1'b0}};
                            req_nxt_s     = 1'b1;
                            we_nxt_s      = 1'b1;
                            addr_nxt_s    = ex_result[AW-1:0];
                            wdata_nxt_s   = ex_sdata;
                            is_load_nxt_s = 1'b0;
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    req_nxt_s = 1'b0;
                    we_nxt_s  = 1'b0;
                    cnt_nxt_s = {CW{1'b0}};
                    if (is_load_r) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (cnt_r == CNT_MAX) begin
                    req_nxt_s   = 1'b0;
                    we_nxt_s    = 1'b0;
                    busy_nxt_s  = {NR{1'b0}};
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    wb_en_s       = 1'b1;
                    wb_sel_load_s = 1'b1;
                    busy_nxt_s    = {NR{1'b0}};
                    state_nxt_s   = ST_IDLE;
                end else if (cnt_r == CNT_MAX) begin
                    busy_nxt_s  = {NR{1'b0}};
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                req_nxt_s   = 1'b0;
                we_nxt_s    = 1'b0;
                busy_nxt_s  = {NR{1'b0}};
            end
        endcase
    end

    // FSM, memory-port latches, timeout counter and scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {DW{1'b0}};
            dst_r     <= {RW{1'b0}};
            is_load_r <= 1'b0;
            busy_mask <= {NR{1'b0}};
            err       <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            mem_req   <= req_nxt_s;
            mem_we    <= we_nxt_s;
            mem_addr  <= addr_nxt_s;
            mem_wdata <= wdata_nxt_s;
            dst_r     <= dst_nxt_s;
            is_load_r <= is_load_nxt_s;
            busy_mask <= busy_nxt_s;
            err       <= err_nxt_s;
        end
    end

    wb_reg #(.DW(DW), .RW(RW)) u_wb_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_en      (wb_en_s),
        .sel_load   (wb_sel_load_s),
        .alu_addr   (ex_dst),
        .alu_data   (ex_result),
        .ld_addr    (dst_r),
        .ld_data    (mem_rdata),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_dat_in  (rf_dat_in)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid;
    logic       ex_ready;
    logic [1:0] ex_op;
    logic [1:0] ex_dst;
    logic [7:0] ex_result;
    logic [7:0] ex_sdata;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ready;
    logic       mem_rvalid;
    logic [7:0] mem_rdata;
    logic       rf_wr_en;
    logic [1:0] rf_wr_addr;
    logic [7:0] rf_dat_in;
    logic [3:0] busy_mask;
    logic       err;

    int checks_cnt   = 0;
    int failures_cnt = 0;
    int wait_cnt;
    logic saw_wr;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_op      (ex_op),
        .ex_dst     (ex_dst),
        .ex_result  (ex_result),
        .ex_sdata   (ex_sdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_dat_in  (rf_dat_in),
        .busy_mask  (busy_mask),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [1:0] dst,
                           input logic [7:0] res, input logic [7:0] sd);
        ex_valid  = 1'b1;
        ex_op     = op;
        ex_dst    = dst;
        ex_result = res;
        ex_sdata  = sd;
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_op = 2'b00; ex_dst = 2'd0;
        ex_result = 8'h00; ex_sdata = 8'h00; mem_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 8'h00;
        #12;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        chk("rst_busy", {28'd0, busy_mask}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // ALU writeback, latency 1, single cycle
        present(2'b01, 2'd2, 8'h5A, 8'h00);
        tick();
        ex_valid = 1'b0;
        chk("alu_wr_en", {31'd0, rf_wr_en}, 32'd1);
        chk("alu_addr", {30'd0, rf_wr_addr}, 32'd2);
        chk("alu_data", {24'd0, rf_dat_in}, 32'h5A);
        tick();
        chk("alu_pulse", {31'd0, rf_wr_en}, 32'd0);

        // LOAD at minimum latency
        present(2'b10, 2'd1, 8'h10, 8'h00);
        tick();
        ex_valid = 1'b0;
        chk("ld_req", {31'd0, mem_req}, 32'd1);
        chk("ld_we", {31'd0, mem_we}, 32'd0);
        chk("ld_addr", {24'd0, mem_addr}, 32'h10);
        chk("ld_busy1", {28'd0, busy_mask}, 32'h2);
        chk("ld_rdy1", {31'd0, ex_ready}, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("ld_req_drop", {31'd0, mem_req}, 32'd0);
        chk("ld_busy2", {28'd0, busy_mask}, 32'h2);
        chk("ld_rdy2", {31'd0, ex_ready}, 32'd0);
        chk("ld_nowr2", {31'd0, rf_wr_en}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 8'hC3;
        tick();
        mem_rvalid = 1'b0;
        chk("ld_wr_en", {31'd0, rf_wr_en}, 32'd1);
        chk("ld_wr_addr", {30'd0, rf_wr_addr}, 32'd1);
        chk("ld_wr_data", {24'd0, rf_dat_in}, 32'hC3);
        chk("ld_busy3", {28'd0, busy_mask}, 32'h0);
        chk("ld_rdy3", {31'd0, ex_ready}, 32'd1);
        tick();
        chk("ld_pulse", {31'd0, rf_wr_en}, 32'd0);

        // STORE with 3 cycles of backpressure
        present(2'b11, 2'd3, 8'h20, 8'h77);
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("st_req", {31'd0, mem_req}, 32'd1);
            chk("st_we", {31'd0, mem_we}, 32'd1);
            chk("st_addr", {24'd0, mem_addr}, 32'h20);
            chk("st_wdata", {24'd0, mem_wdata}, 32'h77);
            chk("st_nowr", {31'd0, rf_wr_en}, 32'd0);
            chk("st_busy", {28'd0, busy_mask}, 32'h0);
            chk("st_rdy", {31'd0, ex_ready}, 32'd0);
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        chk("st_idle", {31'd0, ex_ready}, 32'd1);
        chk("st_req_drop", {31'd0, mem_req}, 32'd0);
        chk("st_nowr_end", {31'd0, rf_wr_en}, 32'd0);

        // Back-to-back: ALU accepted in the LOAD writeback cycle
        present(2'b10, 2'd3, 8'h30, 8'h00);
        tick();
        ex_valid = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 8'hA5;
        tick();
        mem_rvalid = 1'b0;
        chk("b2b_wr1_en", {31'd0, rf_wr_en}, 32'd1);
        chk("b2b_wr1_addr", {30'd0, rf_wr_addr}, 32'd3);
        chk("b2b_wr1_data", {24'd0, rf_dat_in}, 32'hA5);
        chk("b2b_rdy", {31'd0, ex_ready}, 32'd1);
        present(2'b01, 2'd0, 8'h3C, 8'h00);
        tick();
        ex_valid = 1'b0;
        chk("b2b_wr2_en", {31'd0, rf_wr_en}, 32'd1);
        chk("b2b_wr2_addr", {30'd0, rf_wr_addr}, 32'd0);
        chk("b2b_wr2_data", {24'd0, rf_dat_in}, 32'h3C);
        tick();
        chk("b2b_end", {31'd0, rf_wr_en}, 32'd0);

        // Stray rvalid while idle is ignored
        mem_rvalid = 1'b1; mem_rdata = 8'hEE;
        tick();
        mem_rvalid = 1'b0;
        tick();
        chk("stray_rvalid", {31'd0, rf_wr_en}, 32'd0);

        // Timeout in WAIT
        present(2'b10, 2'd2, 8'h40, 8'h00);
        tick();
        ex_valid = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        saw_wr = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            saw_wr = saw_wr | rf_wr_en;
        end
        chk("tmo_err_early", {31'd0, err}, 32'd0);
        chk("tmo_busy_early", {28'd0, busy_mask}, 32'h4);
        wait_cnt = 0;
        while (!ex_ready && wait_cnt < 10) begin
            tick();
            saw_wr = saw_wr | rf_wr_en;
            wait_cnt++;
        end
        chk("tmo_idle", {31'd0, ex_ready}, 32'd1);
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_busy", {28'd0, busy_mask}, 32'h0);
        tick();
        saw_wr = saw_wr | rf_wr_en;
        chk("tmo_nowr", {31'd0, saw_wr}, 32'd0);
        present(2'b01, 2'd1, 8'h99, 8'h00);
        tick();
        ex_valid = 1'b0;
        chk("tmo_alu_en", {31'd0, rf_wr_en}, 32'd1);
        chk("tmo_alu_addr", {30'd0, rf_wr_addr}, 32'd1);
        chk("tmo_alu_data", {24'd0, rf_dat_in}, 32'h99);
        tick();
        chk("tmo_err_sticky", {31'd0, err}, 32'd1);

        // Async reset while a LOAD waits for data
        present(2'b10, 2'd0, 8'h50, 8'h00);
        tick();
        ex_valid = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rst2_busy_pre", {28'd0, busy_mask}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_busy", {28'd0, busy_mask}, 32'h0);
        chk("rst2_err", {31'd0, err}, 32'd0);
        chk("rst2_req", {31'd0, mem_req}, 32'd0);
        chk("rst2_addr", {24'd0, mem_addr}, 32'h0);
        chk("rst2_wr_en", {31'd0, rf_wr_en}, 32'd0);
        chk("rst2_wr_data", {24'd0, rf_dat_in}, 32'h0);
        chk("rst2_rdy", {31'd0, ex_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 8'h11;
        saw_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            saw_wr = saw_wr | rf_wr_en;
        end
        mem_rvalid = 1'b0;
        chk("rst2_nowr", {31'd0, saw_wr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
